// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: state encoding, default line
// parameters and the frame width.
package uart_pkg;

  localparam int DEFAULT_CLK_FREQ = 50_000_000;
  localparam int DEFAULT_BAUD     = 9600;
  localparam int DATA_BITS        = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator; emits a one-cycle tick every
// CLK_FREQ/(BAUD*OVERSAMPLE) clocks and is never resynchronised to frames.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == CNT_LAST);
  assign tick    = at_last;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (at_last) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver with a valid/ready byte output, framing
// error pulse and sticky overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_line,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_PRE_S0 = CNT_W'(OVERSAMPLE - 3);
  localparam logic [CNT_W-1:0] CNT_PRE_S1 = CNT_W'(OVERSAMPLE - 2);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);

  logic                 tick;
  logic                 sync1_q, sync2_q;
  logic                 rx_s;

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           smp_q, smp_d;

  logic                 start_seen;
  logic                 half_pt;
  logic                 bit_mid;
  logic                 mid_level;
  logic                 good_frame;
  logic                 bad_frame;

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_err_q, frame_err_d;

  uart_baud_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_line;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s       = sync2_q;
  assign cnt_inc    = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  assign start_seen = tick && !rx_s;
  assign half_pt    = tick && (cnt_q == CNT_HALF);
  assign bit_mid    = tick && (cnt_q == CNT_LAST);
  assign mid_level  = majority3(smp_q[0], smp_q[1], rx_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_seen) state_d = START;
      START:     if (half_pt) state_d = rx_s ? IDLE : DATA;
      DATA:      if (bit_mid && (bit_idx_q == IDX_LAST)) state_d = STOP;
      STOP:      if (bit_mid) state_d = mid_level ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (tick && rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_busy    = (state_q != IDLE);
    good_frame = (state_q == STOP) && bit_mid && mid_level;
    bad_frame  = (state_q == STOP) && bit_mid && !mid_level;
  end

  // The bit decision lands on the tick where the count wraps to zero; the
  // two earlier samples of the majority vote are captured just before it.
  always_comb begin
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    smp_d     = smp_q;
    case (state_q)
      IDLE: begin
        if (start_seen) cnt_d = '0;
      end
      START: begin
        if (half_pt) begin
          cnt_d     = '0;
          bit_idx_d = '0;
        end else if (tick) begin
          cnt_d = cnt_inc;
        end
      end
      DATA, STOP: begin
        if (tick) begin
          cnt_d = cnt_inc;
          if (cnt_q == CNT_PRE_S0) smp_d[0] = rx_s;
          if (cnt_q == CNT_PRE_S1) smp_d[1] = rx_s;
          if ((state_q == DATA) && (cnt_q == CNT_LAST)) begin
            shift_d   = {mid_level, shift_q[DATA_BITS-1:1]};
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      smp_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      smp_q     <= smp_d;
    end
  end

  // A new byte may load in the same cycle the previous one is accepted.
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = bad_frame;
    if (good_frame && (!rx_valid_q || rx_ready)) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (good_frame && rx_valid_q && !rx_ready) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx at 16 clocks per bit, compared
// against a byte-level model of what the consumer should observe.
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       rxLine;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxReady;
  logic       rxBusy;
  logic       frameErr;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] gotQ[$];
  logic [7:0] expQ[$];
  int validRises = 0;
  int ferrPulses = 0;
  int ferrCycles = 0;
  int busyRun = 0;
  int lastBusyRun = 0;
  int busyFallCyc = 0;
  logic prevValid = 1'b0;
  logic prevFerr = 1'b0;

  int frameStartCyc = 0;
  logic mPending = 1'b0;
  logic [7:0] mData = 8'h00;
  logic mOverrun = 1'b0;

  uart_rx #(
    .CLK_FREQ  (1_600_000),
    .BAUD      (100_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_line  (rxLine),
    .rx_data  (rxData),
    .rx_valid (rxValid),
    .rx_ready (rxReady),
    .rx_busy  (rxBusy),
    .frame_err(frameErr),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the consumer side half a cycle away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      busyRun   = 0;
      prevValid = 1'b0;
      prevFerr  = 1'b0;
    end else begin
      if (rxValid && rxReady) gotQ.push_back(rxData);
      if (rxValid && !prevValid) validRises++;
      if (frameErr) begin
        ferrCycles++;
        if (!prevFerr) ferrPulses++;
      end
      if (rxBusy) begin
        busyRun++;
      end else if (busyRun != 0) begin
        lastBusyRun = busyRun;
        busyFallCyc = cyc;
        busyRun     = 0;
      end
      prevValid = rxValid;
      prevFerr  = frameErr;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one 8N1 frame; with jitter each bit boundary moves by -1/0/+1 clk.
  task automatic applyStimulus(input logic [7:0] b, input logic stopLvl,
                               input int stopLen, input bit jitter);
    int   off[10];
    logic lvl[9];
    off[0] = 0;
    for (int k = 1; k < 10; k++) off[k] = jitter ? int'($urandom_range(2)) - 1 : 0;
    lvl[0] = 1'b0;
    for (int k = 1; k < 9; k++) lvl[k] = b[k-1];
    frameStartCyc = cyc;
    for (int k = 0; k < 9; k++) begin
      rxLine = lvl[k];
      step(16 + off[k+1] - off[k]);
    end
    rxLine = stopLvl;
    step(stopLen - off[9]);
    rxLine = 1'b1;
  endtask

  // Byte-level consumer model: what should appear at the handshake.
  task automatic modelFrame(input logic [7:0] b, input bit good);
    if (good) begin
      if (rxReady) expQ.push_back(b);
      else if (!mPending) begin
        mPending = 1'b1;
        mData    = b;
      end else mOverrun = 1'b1;
    end
  endtask

  task automatic modelRelease();
    if (mPending) expQ.push_back(mData);
    mPending = 1'b0;
  endtask

  task automatic checkQueues(input string tag);
    checkOutput({tag, " count"}, gotQ.size(), expQ.size());
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++)
      checkOutput({tag, " byte"}, gotQ[i], expQ[i]);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " rx_valid"}, rxValid, 0);
    checkOutput({tag, " rx_data"}, rxData, 0);
    checkOutput({tag, " rx_busy"}, rxBusy, 0);
    checkOutput({tag, " frame_err"}, frameErr, 0);
    checkOutput({tag, " overrun"}, overrun, 0);
  endtask

  initial begin
    int vr, fp, fc;
    logic [7:0] rb;
    logic [7:0] trio[3];
    trio[0] = 8'h55;
    trio[1] = 8'h00;
    trio[2] = 8'hFF;

    rst_n   = 1'b0;
    rxLine  = 1'b1;
    rxReady = 1'b1;
    step(3);
    checkAllZero("reset");
    rst_n = 1'b1;
    step(5);

    $display("[TB] good frame 0xA5");
    vr = validRises; fp = ferrPulses;
    applyStimulus(8'hA5, 1'b1, 16, 1'b0);
    modelFrame(8'hA5, 1'b1);
    step(10);
    checkOutput("A5 valid rises", validRises - vr, 1);
    checkOutput("A5 frame_err", ferrPulses - fp, 0);
    checkOutput("A5 rx_data", rxData, 8'hA5);
    checkOutput("A5 busy fall window",
                (busyFallCyc - frameStartCyc >= 152) && (busyFallCyc - frameStartCyc <= 162), 1);
    checkQueues("A5");

    $display("[TB] false start");
    vr = validRises;
    rxLine = 1'b0;
    step(5);
    rxLine = 1'b1;
    step(20);
    checkOutput("false start valid", validRises - vr, 0);
    checkOutput("false start busy width ok", (lastBusyRun >= 1) && (lastBusyRun <= 10), 1);
    checkOutput("false start busy idle", rxBusy, 0);

    $display("[TB] framing error 0x3C then 0x81");
    vr = validRises; fp = ferrPulses; fc = ferrCycles;
    applyStimulus(8'h3C, 1'b0, 16, 1'b0);
    modelFrame(8'h3C, 1'b0);
    step(10);
    checkOutput("ferr pulses", ferrPulses - fp, 1);
    checkOutput("ferr width", ferrCycles - fc, 1);
    checkOutput("ferr no valid", validRises - vr, 0);
    checkOutput("ferr busy released", rxBusy, 0);
    applyStimulus(8'h81, 1'b1, 16, 1'b0);
    modelFrame(8'h81, 1'b1);
    step(10);
    checkQueues("after ferr");

    $display("[TB] overrun 0x11 then 0x22");
    rxReady = 1'b0;
    applyStimulus(8'h11, 1'b1, 16, 1'b0);
    modelFrame(8'h11, 1'b1);
    step(5);
    applyStimulus(8'h22, 1'b1, 16, 1'b0);
    modelFrame(8'h22, 1'b1);
    step(10);
    checkOutput("ovr rx_valid", rxValid, mPending);
    checkOutput("ovr rx_data", rxData, mData);
    checkOutput("ovr overrun", overrun, mOverrun);
    rxReady = 1'b1;
    modelRelease();
    step(1);
    checkOutput("ovr valid drops", rxValid, 0);
    checkQueues("ovr");

    $display("[TB] back-to-back with edge jitter");
    fp = ferrPulses;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(trio[i], 1'b1, 9, 1'b1);
      modelFrame(trio[i], 1'b1);
    end
    step(20);
    checkOutput("b2b frame_err", ferrPulses - fp, 0);
    checkQueues("b2b");

    $display("[TB] random frames");
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      applyStimulus(rb, 1'b1, 16, 1'($urandom_range(1)));
      modelFrame(rb, 1'b1);
      step(int'($urandom_range(20)));
    end
    step(10);
    checkQueues("random");

    $display("[TB] reset during bit 4 of 0x5A");
    vr = validRises;
    fork
      applyStimulus(8'h5A, 1'b1, 16, 1'b0);
      begin
        step(16 * 5 + 8);
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
      end
    join
    mPending = 1'b0;
    mOverrun = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(5);
    checkOutput("midreset no byte", validRises - vr, 0);
    checkOutput("midreset overrun", overrun, mOverrun);
    applyStimulus(8'hC3, 1'b1, 16, 1'b0);
    modelFrame(8'hC3, 1'b1);
    step(10);
    checkOutput("C3 rx_data", rxData, 8'hC3);
    checkQueues("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
